// File: rtl/frame_painter.sv
// frame_painter: turns the scan-counter (x,y) sweep into VGA-adapter plot writes.
// Blanks one full frame after sync, then paints a double-buffered ball and paddle every frame.
module frame_painter #(
  parameter int          X_RES         = 160,
  parameter int          Y_RES         = 120,
  parameter int          X_MAX         = 160,
  parameter int          Y_MAX         = 120,
  parameter int          BALL_SIZE     = 4,
  parameter int          PADDLE_W      = 16,
  parameter int          PADDLE_H      = 2,
  parameter int          PADDLE_Y      = 112,
  parameter logic [2:0]  BALL_COLOUR   = 3'b111,
  parameter logic [2:0]  PADDLE_COLOUR = 3'b010,
  parameter logic [2:0]  BG_COLOUR     = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic       obj_load,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  input  logic [7:0] paddle_x,
  output logic       obj_ack,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    CLEAR = 2'd1,
    DRAW  = 2'd2
  } state_t;

  state_t     state, state_nxt;

  logic [7:0] pend_bx, pend_px, act_bx, act_px, cur_bx, cur_px;
  logic [6:0] pend_by, act_by, cur_by;

  logic       frame_start, frame_end, copy_obj, on_screen;
  logic       hit_ball, hit_paddle;
  logic [2:0] colour_p0;
  logic       vld_p0;

  logic [7:0] x_p1;
  logic [6:0] y_p1;
  logic [2:0] colour_p1;
  logic       vld_p1, done_p1, ack_p1;

  // Bounds are evaluated one bit wider than the coordinate so objects near
  // the right/bottom edge are clipped instead of wrapping back to 0.
  function automatic logic in_span(input logic [8:0] v, input logic [8:0] lo,
                                   input logic [8:0] len);
    return (v >= lo) && (v < lo + len);
  endfunction

  // Stage p0: frame detection, state update and colour decision
  always_comb begin
    frame_start = (x_in == 8'd0) && (y_in == 7'd0);
    frame_end   = (x_in == 8'(X_MAX)) && (y_in == 7'(Y_MAX));
    on_screen   = ({1'b0, x_in} < 9'(X_RES)) && ({1'b0, y_in} < 8'(Y_RES));

    state_nxt = state;
    case (state)
      SYNC:    if (frame_start) state_nxt = CLEAR;
      CLEAR:   if (frame_end)   state_nxt = DRAW;
      DRAW:    state_nxt = DRAW;
      default: state_nxt = SYNC;
    endcase

    // The pending->active copy is visible to the frame-start pixel itself.
    copy_obj = (state == DRAW) && frame_start;
    cur_bx   = copy_obj ? pend_bx : act_bx;
    cur_by   = copy_obj ? pend_by : act_by;
    cur_px   = copy_obj ? pend_px : act_px;

    hit_ball   = in_span({1'b0, x_in}, {1'b0, cur_bx}, 9'(BALL_SIZE)) &&
                 in_span({2'b00, y_in}, {2'b00, cur_by}, 9'(BALL_SIZE));
    hit_paddle = in_span({1'b0, x_in}, {1'b0, cur_px}, 9'(PADDLE_W)) &&
                 in_span({2'b00, y_in}, 9'(PADDLE_Y), 9'(PADDLE_H));

    colour_p0 = BG_COLOUR;
    if (state_nxt == DRAW) begin
      if (hit_ball)        colour_p0 = BALL_COLOUR;
      else if (hit_paddle) colour_p0 = PADDLE_COLOUR;
    end

    vld_p0 = (state_nxt != SYNC) && on_screen;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= SYNC;
      pend_bx <= '0;
      pend_by <= '0;
      pend_px <= '0;
      act_bx  <= '0;
      act_by  <= '0;
      act_px  <= '0;
    end else begin
      state <= state_nxt;
      if (copy_obj) begin
        act_bx <= pend_bx;
        act_by <= pend_by;
        act_px <= pend_px;
      end
      if (obj_load) begin
        pend_bx <= ball_x;
        pend_by <= ball_y;
        pend_px <= paddle_x;
      end
    end
  end

  // Stage p1: registered outputs to the VGA adapter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_p1      <= '0;
      y_p1      <= '0;
      colour_p1 <= '0;
      vld_p1    <= 1'b0;
      done_p1   <= 1'b0;
      ack_p1    <= 1'b0;
    end else begin
      x_p1      <= x_in;
      y_p1      <= y_in;
      colour_p1 <= colour_p0;
      vld_p1    <= vld_p0;
      done_p1   <= frame_end && (state != SYNC);
      ack_p1    <= obj_load;
    end
  end

  assign x_out      = x_p1;
  assign y_out      = y_p1;
  assign colour     = colour_p1;
  assign plot       = vld_p1;
  assign frame_done = done_p1;
  assign obj_ack    = ack_p1;

endmodule

// File: tb/tb_frame_painter.sv
// Directed bench for frame_painter: a reference model pushes expected outputs per driven
// pixel into a scoreboard; directed pixel checks cover the object/edge cases.
module tb_frame_painter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic       obj_load = 1'b0;
  logic [7:0] ball_x = '0;
  logic [6:0] ball_y = '0;
  logic [7:0] paddle_x = '0;
  logic       obj_ack;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic       frame_done;

  always #5 clock = ~clock;

  frame_painter dut (
    .clock      (clock),
    .reset      (reset),
    .x_in       (x_in),
    .y_in       (y_in),
    .obj_load   (obj_load),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle_x   (paddle_x),
    .obj_ack    (obj_ack),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour     (colour),
    .plot       (plot),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic       plot;
    logic [2:0] col;
    logic       fd;
    logic       ack;
  } exp_t;

  exp_t sbq[$];

  int ntests = 0;
  int nfail  = 0;
  int plot_cnt, fd_cnt, nonbg_cnt;

  // Reference model: 0=sync, 1=clear, 2=draw
  int m_state = 0;
  int m_pbx = 0, m_pby = 0, m_ppx = 0;
  int m_abx = 0, m_aby = 0, m_apx = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] model_colour(input int x, input int y);
    int dx, dy;
    dx = x - m_abx;
    dy = y - m_aby;
    if (dx >= 0 && dx < 4 && dy >= 0 && dy < 4) return 3'b111;
    dx = x - m_apx;
    if (dx >= 0 && dx < 16 && y >= 112 && y < 114) return 3'b010;
    return 3'b000;
  endfunction

  task automatic step(input int x, input int y, input bit load);
    exp_t e;
    int   ns;
    bit   fs, fe;
    x_in     = 8'(x);
    y_in     = 7'(y);
    obj_load = load;
    fs = (x == 0) && (y == 0);
    fe = (x == 160) && (y == 120);
    ns = m_state;
    if (m_state == 0 && fs) ns = 1;
    else if (m_state == 1 && fe) ns = 2;
    if (m_state == 2 && fs) begin
      m_abx = m_pbx;
      m_aby = m_pby;
      m_apx = m_ppx;
    end
    e.x    = 8'(x);
    e.y    = 7'(y);
    e.ack  = load;
    e.fd   = fe && (m_state != 0);
    e.plot = (ns != 0) && (x < 160) && (y < 120);
    e.col  = (ns == 2) ? model_colour(x, y) : 3'b000;
    if (load) begin
      m_pbx = int'(ball_x);
      m_pby = int'(ball_y);
      m_ppx = int'(paddle_x);
    end
    m_state = ns;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    obj_load = 1'b0;
    e = sbq.pop_front();
    chk("xy_plot_done_ack", 32'({x_out, y_out, plot, frame_done, obj_ack}),
        32'({e.x, e.y, e.plot, e.fd, e.ack}));
    if (e.plot) chk("colour", 32'(colour), 32'(e.col));
    plot_cnt  += int'(plot);
    fd_cnt    += int'(frame_done);
    if (plot && colour != 3'b000) nonbg_cnt++;
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [2:0] col);
    step(x, y, 1'b0);
    chk(tag, 32'(colour), 32'(col));
    chk({tag, "_plot"}, 32'(plot), 32'd1);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pbx = 0; m_pby = 0; m_ppx = 0;
    m_abx = 0; m_aby = 0; m_apx = 0;
    sbq.delete();
  endtask

  initial begin
    logic [2:0] c_origin, c_late;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", 32'({x_out, y_out, colour, plot, frame_done, obj_ack}), 32'd0);
    reset = 1'b0;
    model_reset();

    // Sweep picked up mid-frame: nothing plotted until (0,0)
    plot_cnt = 0; fd_cnt = 0;
    for (int x = 37; x <= 160; x++) step(x, 5, 1'b0);
    for (int x = 158; x <= 160; x++) step(x, 120, 1'b0);
    chk("sync_plot_cnt", 32'(plot_cnt), 32'd0);
    chk("sync_fd_cnt", 32'(fd_cnt), 32'd0);

    // Full CLEAR frame
    plot_cnt = 0; fd_cnt = 0; nonbg_cnt = 0;
    for (int y = 0; y <= 120; y++)
      for (int x = 0; x <= 160; x++) step(x, y, 1'b0);
    chk("clear_plot_cnt", 32'(plot_cnt), 32'd19200);
    chk("clear_fd_cnt", 32'(fd_cnt), 32'd1);
    chk("clear_nonbg", 32'(nonbg_cnt), 32'd0);
    chk("clear_fd_last", 32'(frame_done), 32'd1);

    // First DRAW frame with zeroed objects; load ball (10,20) mid-frame
    plot_cnt = 0; fd_cnt = 0;
    c_origin = 3'bxxx; c_late = 3'bxxx;
    for (int y = 0; y <= 120; y++)
      for (int x = 0; x <= 160; x++) begin
        if (x == 0 && y == 60) begin
          ball_x = 8'd10; ball_y = 7'd20; paddle_x = 8'd0;
          step(x, y, 1'b1);
          chk("ack_mid_frame", 32'(obj_ack), 32'd1);
        end else begin
          step(x, y, 1'b0);
        end
        if (x == 1 && y == 1)   c_origin = colour;
        if (x == 13 && y == 23) c_late   = colour;
      end
    chk("draw_plot_cnt", 32'(plot_cnt), 32'd19200);
    chk("draw_fd_cnt", 32'(fd_cnt), 32'd1);
    chk("f2_ball_origin", 32'(c_origin), 32'd7);
    chk("f2_unchanged_13_23", 32'(c_late), 32'd0);

    // Frame 3: loaded ball now visible; load ball (40,111) paddle 38
    step(0, 0, 1'b0);
    pix("f3_13_23", 13, 23, 3'b111);
    pix("f3_14_23", 14, 23, 3'b000);
    pix("f3_10_20", 10, 20, 3'b111);
    ball_x = 8'd40; ball_y = 7'd111; paddle_x = 8'd38;
    step(50, 50, 1'b1);
    chk("ack_f3", 32'(obj_ack), 32'd1);
    step(51, 50, 1'b0);
    chk("ack_single", 32'(obj_ack), 32'd0);
    pix("f3_40_112", 40, 112, 3'b000);
    step(160, 120, 1'b0);

    // Frame 4: ball overlaps paddle; load corner ball
    step(0, 0, 1'b0);
    pix("f4_ball_wins", 40, 112, 3'b111);
    pix("f4_paddle_left", 38, 112, 3'b010);
    pix("f4_paddle_right", 53, 113, 3'b010);
    pix("f4_past_paddle", 54, 113, 3'b000);
    pix("f4_ball_row114", 43, 114, 3'b111);
    ball_x = 8'd158; ball_y = 7'd118; paddle_x = 8'd150;
    step(5, 5, 1'b1);
    step(160, 120, 1'b0);

    // Frame 5: objects clipped at the right/bottom edges
    step(0, 0, 1'b0);
    pix("f5_corner", 159, 119, 3'b111);
    pix("f5_no_wrap_x", 0, 118, 3'b000);
    pix("f5_no_wrap_x1", 1, 119, 3'b000);
    pix("f5_paddle_150", 150, 112, 3'b010);
    pix("f5_paddle_159", 159, 112, 3'b010);
    step(160, 119, 1'b0);
    chk("f5_offscreen_plot", 32'(plot), 32'd0);
    chk("f5_offscreen_x", 32'(x_out), 32'd160);
    ball_x = 8'd80; ball_y = 7'd60; paddle_x = 8'd10;
    step(160, 120, 1'b0);

    // Frame 6: load on the frame-start cycle keeps the old objects this frame
    step(0, 0, 1'b1);
    chk("f6_ack", 32'(obj_ack), 32'd1);
    pix("f6_old_ball", 159, 119, 3'b111);
    pix("f6_new_not_yet", 80, 60, 3'b000);
    step(160, 120, 1'b0);

    // Frame 7: new objects applied
    step(0, 0, 1'b0);
    pix("f7_new_ball", 80, 60, 3'b111);
    pix("f7_new_ball_br", 83, 63, 3'b111);
    pix("f7_old_gone", 159, 119, 3'b000);
    step(20, 20, 1'b0);

    // Asynchronous reset mid-DRAW
    #2;
    reset = 1'b1;
    #1;
    chk("reset_async", 32'({x_out, y_out, colour, plot, frame_done, obj_ack}), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    step(5, 5, 1'b0);
    chk("post_rst_sync_plot", 32'(plot), 32'd0);
    step(160, 120, 1'b0);
    chk("post_rst_sync_fd", 32'(frame_done), 32'd0);
    pix("post_rst_clear_origin", 0, 0, 3'b000);
    pix("post_rst_clear_80_60", 80, 60, 3'b000);
    pix("post_rst_clear_1_1", 1, 1, 3'b000);
    step(160, 120, 1'b0);
    chk("post_rst_clear_fd", 32'(frame_done), 32'd1);
    step(0, 0, 1'b0);
    chk("post_rst_ball_zeroed", 32'(colour), 32'd7);
    pix("post_rst_80_60", 80, 60, 3'b000);
    step(160, 120, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
